// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of the bit_serializer: parallel handshake on one side,
// serial stream and status toward the sequence detector on the other.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x,
        input  x_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x,
        output x_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register for gapless streaming.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
    parameter int WIDTH    = 8,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    bit_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef SER_PARITY_EN
        , S_PAR = 2'd2
`endif
    } state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t           state_r, state_n;
    logic [WIDTH-1:0] shreg_r, shreg_n;
    logic [WIDTH-1:0] hold_r, hold_n;
    logic             hold_full_r, hold_full_n;
    logic [CW-1:0]    bitcnt_r, bitcnt_n;
    logic             x_r, x_n;
    logic             x_valid_r, x_valid_n;
    logic             word_done_r, word_done_n;
    logic             in_ready_s, accept_s, eow_s;
    logic             load_s;
    logic [WIDTH-1:0] load_word_s;
`ifdef SER_PARITY_EN
    logic             par_r, par_n;
`endif

    assign in_ready_s = reset && !hold_full_r;
    assign accept_s   = bus.in_valid && in_ready_s;
`ifdef SER_PARITY_EN
    assign eow_s      = (state_r == S_PAR);
`else
    assign eow_s      = (state_r == S_SHIFT) && (bitcnt_r == LAST_IDX);
`endif

    // Next-state: word loading (bypass or from hold), shifting, hold capture.
    always_comb begin
        state_n     = state_r;
        shreg_n     = shreg_r;
        hold_n      = hold_r;
        hold_full_n = hold_full_r;
        bitcnt_n    = bitcnt_r;
        load_s      = 1'b0;
        load_word_s = {WIDTH{1'b0}};
`ifdef SER_PARITY_EN
        par_n       = par_r;
`endif
        if (eow_s) begin
            if (hold_full_r) begin
                load_s      = 1'b1;
                load_word_s = hold_r;
                hold_full_n = 1'b0;
            end else if (accept_s) begin
                load_s      = 1'b1;
                load_word_s = bus.in_data;
            end else begin
                state_n = S_IDLE;
            end
        end else if (state_r == S_IDLE) begin
            if (accept_s) begin
                load_s      = 1'b1;
                load_word_s = bus.in_data;
            end else begin
                state_n = S_IDLE;
            end
        end else begin
            if (accept_s) begin
                hold_n      = bus.in_data;
                hold_full_n = 1'b1;
            end else begin
                hold_full_n = hold_full_r;
            end
`ifdef SER_PARITY_EN
            if (bitcnt_r == LAST_IDX) begin
                state_n = S_PAR;
            end else begin
                shreg_n  = shreg_r << 1;
                bitcnt_n = bitcnt_r + CW'(1);
            end
`else
            shreg_n  = shreg_r << 1;
            bitcnt_n = bitcnt_r + CW'(1);
`endif
        end

        if (load_s) begin
            state_n  = S_SHIFT;
            shreg_n  = load_word_s;
            bitcnt_n = {CW{1'b0}};
`ifdef SER_PARITY_EN
            par_n    = even_parity(load_word_s);
`endif
        end else begin
            state_n = state_n;
        end
    end

    // Output decode from the upcoming state so x/x_valid/word_done leave registers.
    always_comb begin
        x_n         = IDLE_BIT;
        x_valid_n   = 1'b0;
        word_done_n = 1'b0;
        case (state_n)
            S_IDLE: begin
                x_n       = IDLE_BIT;
                x_valid_n = 1'b0;
            end
            S_SHIFT: begin
                x_n       = shreg_n[WIDTH-1];
                x_valid_n = 1'b1;
`ifdef SER_PARITY_EN
                word_done_n = 1'b0;
`else
                word_done_n = (bitcnt_n == LAST_IDX);
`endif
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
                x_n         = par_n;
                x_valid_n   = 1'b1;
                word_done_n = 1'b1;
            end
`endif
            default: begin
                x_n         = IDLE_BIT;
                x_valid_n   = 1'b0;
                word_done_n = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            shreg_r     <= {WIDTH{1'b0}};
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            bitcnt_r    <= {CW{1'b0}};
            x_r         <= IDLE_BIT;
            x_valid_r   <= 1'b0;
            word_done_r <= 1'b0;
`ifdef SER_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            shreg_r     <= shreg_n;
            hold_r      <= hold_n;
            hold_full_r <= hold_full_n;
            bitcnt_r    <= bitcnt_n;
            x_r         <= x_n;
            x_valid_r   <= x_valid_n;
            word_done_r <= word_done_n;
`ifdef SER_PARITY_EN
            par_r       <= par_n;
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.x         = x_r;
    assign bus.x_valid   = x_valid_r;
    assign bus.word_done = word_done_r;
    assign bus.busy      = (state_r != S_IDLE) || hold_full_r;
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand into a queue of expected
// serial bits; a negedge monitor pops and compares the stream, handshake and status.
module tb_bit_serializer;
    localparam int WIDTH    = 8;
    localparam bit IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
    localparam int BPW = WIDTH + 1;
`else
    localparam int BPW = WIDTH;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en    = 1'b0;
    logic model_rdy = 1'b0;
    logic accepted  = 1'b0;
    logic [1:0] exp_q[$];   // {is_last_bit_of_word, bit}

    bit_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes WIDTH bits MSB-first, plus its even parity when enabled.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_q.push_back({(BPW == WIDTH) && (i == 0), w[i]});
        end
        if (BPW != WIDTH) begin
            exp_q.push_back({1'b1, ^w});
        end
    endtask

    // One rising edge: model the reset or the accept, then drive the next inputs after #1.
    task automatic cycle();
        @(posedge clk);
        accepted = 1'b0;
        if (!reset) begin
            exp_q.delete();
        end else if (bus.in_valid && model_rdy) begin
            push_word(bus.in_data);
            accepted = 1'b1;
        end
        mon_en = 1'b1;
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 4 * BPW; n++) begin
            cycle();
            if (accepted) return;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: compare the presented cycle against the head of the expected stream.
    initial begin
        logic [1:0] head;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready", {31'd0, bus.in_ready}, {31'd0, reset && (exp_q.size() <= BPW)});
                chk("busy", {31'd0, bus.busy}, {31'd0, exp_q.size() > 0});
                chk("x_valid", {31'd0, bus.x_valid}, {31'd0, exp_q.size() > 0});
                model_rdy <= reset && (exp_q.size() <= BPW);
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    chk("x", {31'd0, bus.x}, {31'd0, head[0]});
                    chk("word_done", {31'd0, bus.word_done}, {31'd0, head[1]});
                end else begin
                    chk("x_idle", {31'd0, bus.x}, {31'd0, IDLE_BIT});
                    chk("word_done_idle", {31'd0, bus.word_done}, 32'd0);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b0;
        repeat (3) cycle();
        reset = 1'b1;

        idle(20);

        send_word(8'hB6);
        idle(BPW + 3);

        send_word(8'hB0);
        send_word(8'hB1);
        send_word(8'hFF);
        idle(3 * BPW + 3);

        // Reset at the edge after the third bit is on x.
        send_word(8'hB6);
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        send_word(8'h0F);
        idle(BPW + 3);

        // Second word offered exactly on the first word's end-of-word edge.
        send_word(8'hA5);
        idle(BPW - 1);
        send_word(8'h3C);
        idle(BPW + 3);

        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_data  = WIDTH'($urandom);
            if ($urandom_range(0, 149) == 0) reset = 1'b0;
            else reset = 1'b1;
            cycle();
        end
        reset = 1'b1;
        idle(3 * BPW + 4);
        @(negedge clk);
        chk("drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end that feeds the sequence detector's single-bit `x` input. It accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB-first, one bit per clock, with no gaps between back-to-back words. A 2-word store (shift register plus one holding register) absorbs one word of upstream latency, so the detector sees a continuous stream.

## Interface
Parameters:
- `WIDTH`, default 8: word width; legal range 2..32.
- `IDLE_BIT`, default 0: value driven on `x` whenever `x_valid` is 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (`reset==0` at a rising edge clears all state).
- `in_data`  in  WIDTH  parallel word, MSB transmitted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a data bit this cycle; registered.
- `word_done`  out  1  one-cycle pulse in the cycle the final bit of a word is on `x`; registered.
- `busy`  out  1  shift register or holding register occupied.

## Operation
- Storage: `shreg` (WIDTH bits), `bitcnt`, and `hold` (WIDTH bits) with `hold_full`.
- Accept condition: `in_valid && in_ready` at a rising edge. `in_ready = reset && !hold_full` (combinational).
- States:
  - IDLE: shifter empty.
  - SHIFT: a word is being presented.
  - PAR: parity bit being presented; exists only with `SER_PARITY_EN`.
- IDLE -> SHIFT on accept. The word loads directly into `shreg` (bypassing `hold`), `x` = MSB, `x_valid` = 1.
- SHIFT: each edge presents the next bit and increments `bitcnt`. Bit WIDTH-1 (the LSB) is the last data bit.
- End of word, i.e. the edge after the last bit (the parity bit when enabled):
  - If `hold_full`: load `hold` into `shreg` and clear `hold_full`. The new word's MSB is on `x` in the very next cycle, with no gap.
  - Else if accept occurs at that edge: load `in_data` directly (bypass).
  - Else: go to IDLE; `x_valid` = 0 and `x` = IDLE_BIT.
- An accept while the shifter is occupied and not at end of word writes `hold`.
- An accept at end of word while `hold_full` cannot happen, because `in_ready` is 0.
- `busy` = (state != IDLE) || `hold_full`.
- Reset values (whenever `reset==0` at an edge):
  - state = IDLE, `hold_full` = 0, `bitcnt` = 0.
  - `x` = IDLE_BIT, `x_valid` = 0, `word_done` = 0.
  - `in_ready` = 0 while `reset` is low.
- Reset mid-word: the partial word and any held word are discarded with no further bits emitted. `in_ready` = 1 in the first cycle after release.

## Timing
- Latency: word accepted at edge N appears with its MSB on `x`/`x_valid` in the cycle after edge N. Its LSB appears in the cycle after edge N+WIDTH-1.
- Per-word occupancy: WIDTH cycles, or WIDTH+1 with parity.
- Throughput: one bit per clock sustained while words are available.
- `word_done` is high in the same cycle as the last bit of each word.
- With `in_valid` held high continuously:
  - First word: accepted at edge 0.
  - Second word: accepted into `hold` at edge 1, after which `in_ready` = 0.
  - `in_ready` returns to 1 in the cycle after the edge that moves `hold` into `shreg`.
- The detector samples `x` on the same `clk` edges, so no CDC applies.

## Configuration
- `SER_PARITY_EN` defined: after the LSB, state PAR presents one even-parity bit (XOR of all WIDTH data bits) with `x_valid` = 1. `word_done` is asserted with the parity bit, not the LSB. Occupancy is WIDTH+1 cycles.
- `SER_PARITY_EN` undefined: no PAR state. `word_done` is asserted with the LSB. Occupancy is WIDTH cycles.

## Test plan
- Single word: after reset release, `in_data`=8'hB6 for one cycle -> `x` = 1,0,1,1,0,1,1,0 on 8 consecutive cycles with `x_valid`=1. `word_done` is high only in the 8th cycle, then `x_valid`=0 and `x`=IDLE_BIT. The detector fires on the leading 1011.
- Back-to-back: `in_valid` held with 8'hB0, then 8'hB1, then 8'hFF -> 24 contiguous valid bits with no gap. `in_ready` falls after the 2nd accept and rises once per word boundary. Three `word_done` pulses, 8 cycles apart.
- Idle stream: no `in_valid` for 20 cycles after reset -> `x_valid`=0, `x`=IDLE_BIT, `busy`=0, `in_ready`=1 throughout.
- Reset mid-word: accept 8'hB6, assert `reset`=0 at the edge after the 3rd bit for 1 cycle -> `x_valid`=0 and `busy`=0 from that edge. No remaining bits of 8'hB6 appear. Next word 8'h0F emits 0,0,0,0,1,1,1,1.
- Bypass at boundary: present the 2nd word exactly at the first word's end-of-word edge (hold empty) -> the 2nd word's MSB follows the 1st word's LSB with no gap and `hold_full` never sets.
- Parity (`SER_PARITY_EN`): 8'hB6 -> 9 bits ending in parity 1, with `word_done` on the 9th bit. 8'hB4 -> parity bit 0.
